// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one registered sprite ROM among N_REQ readers.
// Read latency is 2 cycles. Define SPRITE_ARB_LOCK_EN to enable burst locking.
module sprite_rom_arbiter #(
  parameter int N_REQ     = 4,
  parameter int AW        = 16,
  parameter int DW        = 12,
  parameter int ROM_DEPTH = 484,
  parameter int MAX_LOCK  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*AW-1:0]   addr,
  input  logic [N_REQ-1:0]      lock,
  output logic [N_REQ-1:0]      gnt,
  output logic [AW-1:0]         rom_addr,
  output logic                  rom_en,
  input  logic [DW-1:0]         rom_dout,
  output logic                  rvalid,
  output logic [$clog2(N_REQ)-1:0] rid,
  output logic [DW-1:0]         rdata
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic [AW-1:0] sel_addr;
  logic          sel_oor;
  logic          lock_hold;
  logic [IW-1:0] lock_owner;

  logic [IW-1:0] s1_id;
  logic          s1_oor;
  logic          s2_oor;

`ifdef SPRITE_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic          lock_active;
  logic [CW-1:0] lock_cnt;

  // The owner keeps the bus while it holds req and lock, up to MAX_LOCK grants in a row.
  assign lock_hold = lock_active && req[lock_owner] && lock[lock_owner] &&
                     (lock_cnt < CW'(MAX_LOCK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_owner  <= '0;
      lock_cnt    <= '0;
    end else if (gnt_any && lock[gnt_idx]) begin
      if (lock_hold) begin
        lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_active <= 1'b1;
        lock_owner  <= gnt_idx;
        lock_cnt    <= CW'(1);
      end
    end else begin
      lock_active <= 1'b0;
      lock_cnt    <= '0;
    end
  end
`else
  logic unused_lock;

  assign lock_hold   = 1'b0;
  assign lock_owner  = '0;
  assign unused_lock = ^lock;
`endif

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic [IW-1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (lock_hold) begin
      gnt_any = 1'b1;
      gnt_idx = lock_owner;
    end
    if (!rst_n) begin
      gnt_any = 1'b0;
    end
  end

  assign gnt      = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  assign sel_addr = addr[int'(gnt_idx)*AW +: AW];
  assign sel_oor  = (sel_addr >= AW'(ROM_DEPTH));

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Stage 1 drives the ROM; stage 2 lines up with the ROM's registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
      s1_id    <= '0;
      s1_oor   <= 1'b0;
      rvalid   <= 1'b0;
      rid      <= '0;
      s2_oor   <= 1'b0;
    end else begin
      rom_en <= gnt_any;
      if (gnt_any) begin
        rom_addr <= sel_oor ? '0 : sel_addr;
        s1_id    <= gnt_idx;
        s1_oor   <= sel_oor;
      end
      rvalid <= rom_en;
      rid    <= rom_en ? s1_id : '0;
      s2_oor <= rom_en && s1_oor;
    end
  end

  assign rdata = (rvalid && !s2_oor) ? rom_dout : '0;

endmodule
